// File: rtl/ex_mux_pkg.sv
// Shared types and constants for the ex_arb_mux channel multiplexer.
package ex_mux_pkg;

    typedef enum logic {
        MUX_SEL = 1'b0,
        MUX_RR  = 1'b1
    } mux_mode_e;

    localparam int unsigned DATA_SIZE    = 32;
    localparam int unsigned N_IN_DEFAULT = 4;
    localparam int unsigned N_IN_MIN     = 2;
    localparam int unsigned N_IN_MAX     = 16;

endpackage

// File: rtl/ex_rr_arbiter.sv
// Round-robin grant search: first requester at or after ptr, wrapping modulo N_IN.
module ex_rr_arbiter
    import ex_mux_pkg::*;
#(
    parameter int unsigned N_IN = N_IN_DEFAULT,
    localparam int unsigned SEL_W = $clog2(N_IN)
)(
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W:0] w_idx;

    // One spare bit keeps ptr + k from overflowing before the modulo fold.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            w_idx = {1'b0, ptr} + (SEL_W+1)'(k);
            if (w_idx >= (SEL_W+1)'(N_IN)) begin
                w_idx = w_idx - (SEL_W+1)'(N_IN);
            end
            if (!grant_valid && req[w_idx[SEL_W-1:0]]) begin
                grant       = w_idx[SEL_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_arb_mux.sv
// N_IN-to-1 valid/ready multiplexer with a one-entry output register;
// the channel is steered by a select port or chosen round-robin.
module ex_arb_mux
    import ex_mux_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_SIZE,
    parameter int unsigned N_IN   = N_IN_DEFAULT,
    parameter mux_mode_e   MODE   = MUX_SEL,
    localparam int unsigned SEL_W = $clog2(N_IN)
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_IN-1:0][DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]             in_valid,
    output logic [N_IN-1:0]             in_ready,
    input  logic [SEL_W-1:0]            select,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SEL_W-1:0]            out_src,
    output logic                        sel_err
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_src;

    logic              w_load_ok;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_valid;
    logic [N_IN-1:0]   w_in_ready;
    logic              w_accept;
    logic              w_sel_err;

    assign w_load_ok = !r_out_valid || out_ready;

    if (MODE == MUX_RR) begin : g_rr
        logic [SEL_W-1:0] r_ptr;
        logic             w_unused_sel;

        assign w_unused_sel = ^select;
        assign w_sel_err    = 1'b0;

        ex_rr_arbiter #(
            .N_IN (N_IN)
        ) u_arb (
            .req         (in_valid),
            .ptr         (r_ptr),
            .grant       (w_grant),
            .grant_valid (w_grant_valid)
        );

        // Pointer moves just past the accepted channel; explicit wrap for non-power-of-two N_IN.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ptr <= '0;
            end else if (w_accept) begin
                r_ptr <= (w_grant == SEL_W'(N_IN - 1)) ? '0 : w_grant + SEL_W'(1);
            end
        end
    end else begin : g_sel
        assign w_grant       = select;
        assign w_grant_valid = ({1'b0, select} < (SEL_W+1)'(N_IN));
        assign w_sel_err     = !rst && w_load_ok && !w_grant_valid;
    end

    // Only the granted channel can see ready, and only when the register can take a beat.
    always_comb begin
        w_in_ready = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!rst && w_load_ok && w_grant_valid && (w_grant == SEL_W'(i))) begin
                w_in_ready[i] = 1'b1;
            end
        end
    end

    assign w_accept = |(in_valid & w_in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[w_grant];
            r_out_src   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel_err   = w_sel_err;

endmodule

// File: tb/tb_ex_arb_mux.sv
// Scoreboard bench for ex_arb_mux in select and round-robin modes.
module tb_ex_arb_mux;
    import ex_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  src;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    int n_checks = 0;
    int n_fail   = 0;

    // d0: MUX_SEL N=4
    logic [3:0][31:0] d0_in_data;
    logic [3:0]       d0_in_valid, d0_in_ready;
    logic [1:0]       d0_select, d0_out_src;
    logic [31:0]      d0_out_data;
    logic             d0_out_valid, d0_out_ready, d0_sel_err;
    // d1: MUX_RR N=4
    logic [3:0][31:0] d1_in_data;
    logic [3:0]       d1_in_valid, d1_in_ready;
    logic [1:0]       d1_select, d1_out_src;
    logic [31:0]      d1_out_data;
    logic             d1_out_valid, d1_out_ready, d1_sel_err;
    // d2: MUX_SEL N=3
    logic [2:0][31:0] d2_in_data;
    logic [2:0]       d2_in_valid, d2_in_ready;
    logic [1:0]       d2_select, d2_out_src;
    logic [31:0]      d2_out_data;
    logic             d2_out_valid, d2_out_ready, d2_sel_err;
    // d3: MUX_RR N=5
    logic [4:0][31:0] d3_in_data;
    logic [4:0]       d3_in_valid, d3_in_ready;
    logic [2:0]       d3_select, d3_out_src;
    logic [31:0]      d3_out_data;
    logic             d3_out_valid, d3_out_ready, d3_sel_err;

    ex_arb_mux #(.DATA_W(32), .N_IN(4), .MODE(MUX_SEL)) u_d0 (
        .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_ready(d0_in_ready), .select(d0_select), .out_data(d0_out_data),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_src(d0_out_src),
        .sel_err(d0_sel_err));
    ex_arb_mux #(.DATA_W(32), .N_IN(4), .MODE(MUX_RR)) u_d1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_ready(d1_in_ready), .select(d1_select), .out_data(d1_out_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_src(d1_out_src),
        .sel_err(d1_sel_err));
    ex_arb_mux #(.DATA_W(32), .N_IN(3), .MODE(MUX_SEL)) u_d2 (
        .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_ready(d2_in_ready), .select(d2_select), .out_data(d2_out_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_src(d2_out_src),
        .sel_err(d2_sel_err));
    ex_arb_mux #(.DATA_W(32), .N_IN(5), .MODE(MUX_RR)) u_d3 (
        .clk(clk), .rst(rst), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .select(d3_select), .out_data(d3_out_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_src(d3_out_src),
        .sel_err(d3_sel_err));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cmp_beat(input string nm, input logic [31:0] d, input logic [3:0] s, input exp_t e);
        chk({nm, " data"}, 64'(d), 64'(e.data));
        chk({nm, " src"},  64'(s), 64'(e.src));
    endtask

    task automatic no_exp(input string nm, input logic [31:0] d);
        n_checks++;
        n_fail++;
        $display("FAIL %s unexpected beat: got data 0x%0h, want no beat", nm, d);
    endtask

    function automatic exp_t mk(input logic [31:0] d, input int s);
        exp_t e;
        e.data = d;
        e.src  = 4'(s);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every cycle with out_valid && out_ready consumes exactly one expected beat.
    always @(negedge clk) begin
        if (!rst && d0_out_valid && d0_out_ready) begin
            if (q0.size() > 0) cmp_beat("d0 beat", d0_out_data, 4'(d0_out_src), q0.pop_front());
            else no_exp("d0", d0_out_data);
        end
    end
    always @(negedge clk) begin
        if (!rst && d1_out_valid && d1_out_ready) begin
            if (q1.size() > 0) cmp_beat("d1 beat", d1_out_data, 4'(d1_out_src), q1.pop_front());
            else no_exp("d1", d1_out_data);
        end
    end
    always @(negedge clk) begin
        if (!rst && d2_out_valid && d2_out_ready) begin
            if (q2.size() > 0) cmp_beat("d2 beat", d2_out_data, 4'(d2_out_src), q2.pop_front());
            else no_exp("d2", d2_out_data);
        end
    end
    always @(negedge clk) begin
        if (!rst && d3_out_valid && d3_out_ready) begin
            if (q3.size() > 0) cmp_beat("d3 beat", d3_out_data, 4'(d3_out_src), q3.pop_front());
            else no_exp("d3", d3_out_data);
        end
    end

    logic [4:0] rr5_valid [5];
    int         rr5_grant [5];

    initial begin
        rr5_valid = '{5'b01000, 5'b00011, 5'b00011, 5'b10000, 5'b11111};
        rr5_grant = '{3, 0, 1, 4, 0};

        rst = 1'b1;
        d0_in_data = '0; d0_in_valid = '0; d0_select = 2'd2; d0_out_ready = 1'b1;
        d1_in_data = '0; d1_in_valid = '1; d1_select = '0;   d1_out_ready = 1'b1;
        d2_in_data = '0; d2_in_valid = '1; d2_select = 2'd3; d2_out_ready = 1'b1;
        d3_in_data = '0; d3_in_valid = '0; d3_select = '0;   d3_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d1_in_data[i] = 32'hD100_0000 + 32'(i);

        // Reset: ready and sel_err forced low even with grants that would otherwise be live
        @(negedge clk);
        chk("rst d0 in_ready", 64'(d0_in_ready), 64'h0);
        chk("rst d1 in_ready", 64'(d1_in_ready), 64'h0);
        chk("rst d2 sel_err",  64'(d2_sel_err),  64'h0);
        @(negedge clk);
        chk("rst d0 out_valid", 64'(d0_out_valid), 64'h0);
        chk("rst d0 out_data",  64'(d0_out_data),  64'h0);
        chk("rst d0 out_src",   64'(d0_out_src),   64'h0);
        chk("rst d3 out_valid", 64'(d3_out_valid), 64'h0);

        // d0: basic steer of channel 2
        tick();
        rst = 1'b0;
        d1_in_valid = '0; d2_in_valid = '0; d2_select = '0;
        d0_in_data[0] = 32'hDEAD_0000; d0_in_data[1] = 32'hDEAD_0001;
        d0_in_data[2] = 32'hA5A5_0002; d0_in_data[3] = 32'hDEAD_0003;
        d0_select = 2'd2; d0_in_valid = 4'b0100; d0_out_ready = 1'b1;
        @(negedge clk);
        chk("d0 sel2 in_ready", 64'(d0_in_ready), 64'h4);
        q0.push_back(mk(32'hA5A5_0002, 2));
        tick();
        d0_in_valid = '0;
        @(negedge clk);
        chk("d0 sel2 out_valid", 64'(d0_out_valid), 64'h1);
        chk("d0 sel2 out_src",   64'(d0_out_src),   64'h2);
        tick();
        @(negedge clk);
        chk("d0 drained out_valid", 64'(d0_out_valid), 64'h0);
        chk("d0 drained data hold", 64'(d0_out_data),  64'hA5A5_0002);

        // d0: backpressure with select toggling, then drain and accept together
        tick();
        d0_select = 2'd1; d0_in_valid = 4'b0010; d0_in_data[1] = 32'hB000_0001;
        @(negedge clk);
        chk("d0 sel1 in_ready", 64'(d0_in_ready), 64'h2);
        q0.push_back(mk(32'hB000_0001, 1));
        for (int i = 0; i < 3; i++) begin
            tick();
            d0_out_ready = 1'b0; d0_in_valid = 4'b1111; d0_select = 2'(i);
            for (int c = 0; c < 4; c++) d0_in_data[c] = 32'hC000_0000 + 32'(c);
            @(negedge clk);
            chk("d0 bp out_valid", 64'(d0_out_valid), 64'h1);
            chk("d0 bp out_data",  64'(d0_out_data),  64'hB000_0001);
            chk("d0 bp out_src",   64'(d0_out_src),   64'h1);
            chk("d0 bp in_ready",  64'(d0_in_ready),  64'h0);
        end
        tick();
        d0_select = 2'd3; d0_out_ready = 1'b1;
        @(negedge clk);
        chk("d0 drain+accept in_ready", 64'(d0_in_ready), 64'h8);
        q0.push_back(mk(32'hC000_0003, 3));
        tick();
        d0_in_valid = '0;
        @(negedge clk);
        chk("d0 refill out_valid", 64'(d0_out_valid), 64'h1);
        tick();
        @(negedge clk);
        chk("d0 final out_valid", 64'(d0_out_valid), 64'h0);
        chk("d0 final src hold",  64'(d0_out_src),   64'h3);

        // d1: round robin, all valid for 6 cycles
        for (int k = 0; k < 6; k++) begin
            tick();
            d1_in_valid = 4'b1111; d1_out_ready = 1'b1; d1_select = 2'(k);
            @(negedge clk);
            chk("d1 rr in_ready", 64'(d1_in_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) chk("d1 rr out_valid", 64'(d1_out_valid), 64'h1);
            chk("d1 rr sel_err", 64'(d1_sel_err), 64'h0);
            q1.push_back(mk(32'hD100_0000 + 32'(k % 4), k % 4));
        end
        tick();
        d1_in_valid = '0;
        @(negedge clk);
        chk("d1 rr last out_valid", 64'(d1_out_valid), 64'h1);
        tick();

        // d2: N=3 select out of range
        d2_in_data[0] = 32'hE000_0000; d2_in_data[1] = 32'hE000_0001; d2_in_data[2] = 32'hE000_0002;
        d2_select = 2'd0; d2_in_valid = 3'b001; d2_out_ready = 1'b1;
        @(negedge clk);
        chk("d2 sel0 in_ready", 64'(d2_in_ready), 64'h1);
        q2.push_back(mk(32'hE000_0000, 0));
        tick();
        d2_select = 2'd3; d2_in_valid = 3'b111;
        @(negedge clk);
        chk("d2 sel3 sel_err",  64'(d2_sel_err),  64'h1);
        chk("d2 sel3 in_ready", 64'(d2_in_ready), 64'h0);
        tick();
        @(negedge clk);
        chk("d2 sel3 out_valid", 64'(d2_out_valid), 64'h0);
        chk("d2 sel3 sel_err2",  64'(d2_sel_err),   64'h1);
        chk("d2 sel3 data hold", 64'(d2_out_data),  64'hE000_0000);
        tick();
        d2_select = 2'd1; d2_in_valid = 3'b000;
        @(negedge clk);
        chk("d2 sel1 sel_err",  64'(d2_sel_err),  64'h0);
        chk("d2 sel1 in_ready", 64'(d2_in_ready), 64'h2);
        tick();
        @(negedge clk);
        chk("d2 idle out_valid", 64'(d2_out_valid), 64'h0);

        // d3: N=5 round robin wrap from 4 to 0
        for (int i = 0; i < 5; i++) d3_in_data[i] = 32'hF000_0000 + 32'(i);
        d3_select = 3'd7; d3_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            d3_in_valid = rr5_valid[k];
            @(negedge clk);
            chk("d3 rr in_ready", 64'(d3_in_ready), 64'(5'b00001 << rr5_grant[k]));
            chk("d3 rr sel_err",  64'(d3_sel_err),  64'h0);
            q3.push_back(mk(32'hF000_0000 + 32'(rr5_grant[k]), rr5_grant[k]));
        end
        tick();
        d3_in_valid = '0;
        @(negedge clk);
        tick();

        // d1: reset while holding a stalled beat
        d1_in_valid = 4'b0100; d1_out_ready = 1'b1;
        @(negedge clk);
        chk("d1 pre-rst in_ready", 64'(d1_in_ready), 64'h4);
        tick();
        d1_out_ready = 1'b0; d1_in_valid = 4'b1111; rst = 1'b1;
        @(negedge clk);
        chk("d1 in rst in_ready",  64'(d1_in_ready),  64'h0);
        chk("d1 in rst out_valid", 64'(d1_out_valid), 64'h1);
        tick();
        rst = 1'b0; d1_out_ready = 1'b1;
        @(negedge clk);
        chk("d1 post-rst out_valid", 64'(d1_out_valid), 64'h0);
        chk("d1 post-rst out_data",  64'(d1_out_data),  64'h0);
        chk("d1 post-rst out_src",   64'(d1_out_src),   64'h0);
        chk("d1 post-rst in_ready",  64'(d1_in_ready),  64'h1);
        q1.push_back(mk(32'hD100_0000, 0));
        tick();
        d1_in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("d1 end out_valid", 64'(d1_out_valid), 64'h0);

        tick();
        chk("q0 drained", 64'(q0.size()), 64'h0);
        chk("q1 drained", 64'(q1.size()), 64'h0);
        chk("q2 drained", 64'(q2.size()), 64'h0);
        chk("q3 drained", 64'(q3.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_arb_mux.md
EX_ARB_MUX -- requirements
Module: ex_arb_mux

Interface
REQ-001 Parameter DATA_W, default `data_size (32), width of every data path.
REQ-002 Parameter N_IN, default 4, number of input channels, legal range 2..16, need not be a power of two.
REQ-003 Parameter MODE, default MUX_SEL, MUX_SEL = steer by select port; MUX_RR = round-robin arbitration.
REQ-004 Localparam SEL_W = $clog2(N_IN).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_data  input  N_IN x DATA_W  per-channel payload.
REQ-008 in_valid  input  N_IN  per-channel beat present.
REQ-009 in_ready  output  N_IN  per-channel beat accepted this cycle.
REQ-010 select  input  SEL_W  channel index, used only in MUX_SEL.
REQ-011 out_data  output  DATA_W  registered payload.
REQ-012 out_valid  output  1  out_data holds a beat.
REQ-013 out_ready  input  1  downstream takes the beat.
REQ-014 out_src  output  SEL_W  channel index of the held beat.
REQ-015 sel_err  output  1  one-cycle pulse, select >= N_IN seen with load possible.

Function
REQ-016 One-entry output register; load_ok = !out_valid || out_ready.
REQ-017 Exactly one channel g (the grant) per cycle, or none; in_ready[i] = load_ok && grant_valid && (i == g), combinational, no other channel ready.
REQ-018 MUX_SEL: grant = select when select < N_IN; grant_valid independent of in_valid[select].
REQ-019 MUX_SEL, select >= N_IN: no grant, all in_ready 0, sel_err = load_ok, register unchanged.
REQ-020 MUX_RR: grant = first i with in_valid[i], searching ptr, ptr+1, ... wrapping modulo N_IN; no grant when all in_valid 0.
REQ-021 MUX_RR: on accept, ptr <= (g+1) mod N_IN, wrapping N_IN-1 to 0 for any N_IN; ptr unchanged otherwise.
REQ-022 Accept (in_valid[g] && in_ready[g]): next cycle out_valid = 1, out_data = in_data[g], out_src = g; latency exactly 1 cycle.
REQ-023 out_valid && out_ready with no accept: out_valid <= 0; out_data, out_src hold previous values.
REQ-024 Drain and accept in the same cycle: new beat replaces old, out_valid stays 1; sustained throughput 1 beat/cycle.
REQ-025 out_valid && !out_ready: out_data, out_src stable, all in_ready 0, ptr frozen; select changes ignored.
REQ-026 in_data of non-granted channels never reaches out_data; no beat is lost or duplicated.
REQ-027 MODE = MUX_RR ignores select, never asserts sel_err.

Reset
REQ-028 While rst = 1 at a clock edge: out_valid <= 0, out_data <= 0, out_src <= 0, ptr <= 0, sel_err = 0.
REQ-029 While rst = 1, all in_ready are 0.
REQ-030 Reset mid-transfer discards the held beat; first post-reset arbitration starts at channel 0.

Structure
REQ-031 Package ex_mux_pkg holds the mode enum (MUX_SEL, MUX_RR), the default N_IN and the legal N_IN range constants.
REQ-032 Round-robin grant logic is sub-module ex_rr_arbiter (N_IN param; inputs req, ptr; outputs grant, grant_valid), instantiated only for MUX_RR.
REQ-033 No latches; the output register is the only datapath storage.

Verification
REQ-034 MUX_SEL, N_IN=4: select=2, in_valid=4'b0100, in_data[2]=32'hA5A5_0002, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hA5A5_0002, out_src=2.
REQ-035 MUX_RR, N_IN=4: all in_valid=1 for 6 cycles, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one beat per cycle.
REQ-036 Backpressure: out_valid=1, out_ready=0 for 3 cycles while select toggles 0..3 -> out_data and out_src constant, in_ready=0; out_ready=1 -> drain plus new accept in the same cycle.
REQ-037 MUX_SEL, N_IN=3: select=3 -> sel_err=1 for that cycle, in_ready=3'b000, out_valid unchanged.
REQ-038 MUX_RR, N_IN=5: ptr at 4, in_valid=5'b00011 -> grant 0 (wrap); then grant 1.
REQ-039 rst asserted with out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0; first grant after release is channel 0 when all valid.
